rvfi_retire_checker: RTL



---
 rtl/rvfi_retire_checker.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rvfi_retire_checker.sv
// rvfi_retire_checker: stateful checker for an NRET-wide RVFI retirement stream.
// It checks order sequencing, channel packing, PC continuity, x0 writes and
// retirement after halt. The first error is latched and held until reset.
// Optional feature macro RVFI_REG_CHECK_EN adds a shadow register file with
// same-cycle forwarding and rs1/rs2 read-back checks (codes 5/6).
module rvfi_retire_checker #(
    parameter int NRET = 1,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET*64-1:0]   rvfi_order,
    input  logic [NRET-1:0]      rvfi_trap,
    input  logic [NRET-1:0]      rvfi_halt,
    input  logic [NRET*XLEN-1:0] rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0] rvfi_pc_wdata,
    input  logic [NRET*5-1:0]    rvfi_rs1_addr,
    input  logic [NRET*5-1:0]    rvfi_rs2_addr,
    input  logic [NRET*5-1:0]    rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0] rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0] rvfi_rs2_rdata,
    input  logic [NRET*XLEN-1:0] rvfi_rd_wdata,
    output logic                 err_valid,
    output logic [2:0]           err_code,
    output logic [1:0]           err_channel,
    output logic [63:0]          err_order,
    output logic [63:0]          retired_count,
    output logic                 halted
);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ORDER    = 3'd1;
    localparam logic [2:0] ERR_PACK     = 3'd2;
    localparam logic [2:0] ERR_PC       = 3'd3;
    localparam logic [2:0] ERR_X0       = 3'd4;
    localparam logic [2:0] ERR_POSTHALT = 3'd7;

    // Control state (reset)
    logic            baseline_q, baseline_d;
    logic            halted_q, halted_d;
    logic            err_valid_q, err_valid_d;
    logic [2:0]      err_code_q, err_code_d;
    logic [1:0]      err_channel_q, err_channel_d;
    logic [63:0]     err_order_q, err_order_d;
    logic [63:0]     retired_count_q, retired_count_d;
    // Data state (only meaningful once baseline_q is set)
    logic [63:0]     next_order_q, next_order_d;
    logic [XLEN-1:0] last_pc_wdata_q, last_pc_wdata_d;
    logic            last_trap_q, last_trap_d;

    // Per-channel working values
    logic            seen_invalid;
    logic [63:0]     nvalid;
    logic [2:0]      code_k;
    logic [63:0]     ord_k;
    logic [XLEN-1:0] pcr_k;
    logic [4:0]      rd_k;
    logic [XLEN-1:0] rdw_k;

`ifdef RVFI_REG_CHECK_EN
    localparam logic [2:0] ERR_RS1 = 3'd5;
    localparam logic [2:0] ERR_RS2 = 3'd6;

    // Shadow of x1..x31; entries are trusted only when their known bit is set.
    logic [XLEN-1:0] shadow_q [1:31];
    logic [XLEN-1:0] shadow_d [1:31];
    logic [31:1]     known_q, known_d;
    logic [4:0]      rs1_k, rs2_k;
    logic [XLEN-1:0] rs1d_k, rs2d_k;
    logic            rs1_bad, rs2_bad;
`else
    logic unused_regcheck;
    assign unused_regcheck = ^{rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata};
`endif

    // Walk the channels oldest-first, running state forward so that higher
    // channels see lower channels' effects (order, PC, halt, rd writes).
    always_comb begin
        baseline_d      = baseline_q;
        halted_d        = halted_q;
        err_valid_d     = err_valid_q;
        err_code_d      = err_code_q;
        err_channel_d   = err_channel_q;
        err_order_d     = err_order_q;
        next_order_d    = next_order_q;
        last_pc_wdata_d = last_pc_wdata_q;
        last_trap_d     = last_trap_q;
        seen_invalid    = 1'b0;
        nvalid          = '0;
        code_k          = ERR_NONE;
        ord_k           = '0;
        pcr_k           = '0;
        rd_k            = '0;
        rdw_k           = '0;
`ifdef RVFI_REG_CHECK_EN
        shadow_d        = shadow_q;
        known_d         = known_q;
        rs1_k           = '0;
        rs2_k           = '0;
        rs1d_k          = '0;
        rs2d_k          = '0;
        rs1_bad         = 1'b0;
        rs2_bad         = 1'b0;
`endif
        for (int k = 0; k < NRET; k++) begin
            code_k = ERR_NONE;
            if (!rvfi_valid[k]) begin
                seen_invalid = 1'b1;
            end else begin
                ord_k = rvfi_order[k*64 +: 64];
                pcr_k = rvfi_pc_rdata[k*XLEN +: XLEN];
                rd_k  = rvfi_rd_addr[k*5 +: 5];
                rdw_k = rvfi_rd_wdata[k*XLEN +: XLEN];
                // First retirement after reset defines the order baseline.
                if (!baseline_d) begin
                    next_order_d = ord_k;
                end
`ifdef RVFI_REG_CHECK_EN
                rs1_k   = rvfi_rs1_addr[k*5 +: 5];
                rs2_k   = rvfi_rs2_addr[k*5 +: 5];
                rs1d_k  = rvfi_rs1_rdata[k*XLEN +: XLEN];
                rs2d_k  = rvfi_rs2_rdata[k*XLEN +: XLEN];
                rs1_bad = (rs1_k == 5'd0) ? (rs1d_k != '0)
                                          : (known_d[rs1_k] && (rs1d_k != shadow_d[rs1_k]));
                rs2_bad = (rs2_k == 5'd0) ? (rs2d_k != '0)
                                          : (known_d[rs2_k] && (rs2d_k != shadow_d[rs2_k]));
`endif
                // Lowest code wins within a channel.
                if (ord_k != next_order_d) begin
                    code_k = ERR_ORDER;
                end else if (seen_invalid) begin
                    code_k = ERR_PACK;
                end else if (baseline_d && !last_trap_d && (pcr_k != last_pc_wdata_d)) begin
                    code_k = ERR_PC;
                end else if ((rd_k == 5'd0) && (rdw_k != '0)) begin
                    code_k = ERR_X0;
`ifdef RVFI_REG_CHECK_EN
                end else if (rs1_bad) begin
                    code_k = ERR_RS1;
                end else if (rs2_bad) begin
                    code_k = ERR_RS2;
`endif
                end else if (halted_d) begin
                    code_k = ERR_POSTHALT;
                end
                // Lowest channel wins across channels; only the first error sticks.
                if ((code_k != ERR_NONE) && !err_valid_d) begin
                    err_valid_d   = 1'b1;
                    err_code_d    = code_k;
                    err_channel_d = 2'(k);
                    err_order_d   = ord_k;
                end
                baseline_d      = 1'b1;
                next_order_d    = next_order_d + 64'd1;
                last_pc_wdata_d = rvfi_pc_wdata[k*XLEN +: XLEN];
                last_trap_d     = rvfi_trap[k];
                halted_d        = halted_d | rvfi_halt[k];
                nvalid          = nvalid + 64'd1;
`ifdef RVFI_REG_CHECK_EN
                // Written after this channel's own reads so it forwards only upward.
                if (!rvfi_trap[k] && (rd_k != 5'd0)) begin
                    shadow_d[rd_k] = rdw_k;
                    known_d[rd_k]  = 1'b1;
                end
`endif
            end
        end
        retired_count_d = retired_count_q + nvalid;
    end

    // Control registers: cleared by reset, which also discards this cycle's retirements.
    always_ff @(posedge clk) begin
        if (reset) begin
            baseline_q      <= 1'b0;
            halted_q        <= 1'b0;
            err_valid_q     <= 1'b0;
            err_code_q      <= ERR_NONE;
            err_channel_q   <= 2'd0;
            err_order_q     <= 64'd0;
            retired_count_q <= 64'd0;
        end else begin
            baseline_q      <= baseline_d;
            halted_q        <= halted_d;
            err_valid_q     <= err_valid_d;
            err_code_q      <= err_code_d;
            err_channel_q   <= err_channel_d;
            err_order_q     <= err_order_d;
            retired_count_q <= retired_count_d;
        end
    end

    // Data registers: no reset needed, they are ignored until the baseline is set.
    always_ff @(posedge clk) begin
        next_order_q    <= next_order_d;
        last_pc_wdata_q <= last_pc_wdata_d;
        last_trap_q     <= last_trap_d;
    end

`ifdef RVFI_REG_CHECK_EN
    // Known bits are control (reset); shadow contents are data.
    always_ff @(posedge clk) begin
        if (reset) begin
            known_q <= '0;
        end else begin
            known_q <= known_d;
        end
        for (int i = 1; i < 32; i++) begin
            shadow_q[i] <= shadow_d[i];
        end
    end
`endif

    assign err_valid     = err_valid_q;
    assign err_code      = err_code_q;
    assign err_channel   = err_channel_q;
    assign err_order     = err_order_q;
    assign retired_count = retired_count_q;
    assign halted        = halted_q;

endmodule
